// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and helpers for the SAR compare controller
package sar_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_TRY  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Exactly one of the three comparator flags may be high for a trustworthy compare.
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/sar_bit_ptr.sv
// rtl/sar_bit_ptr.sv - one-hot bit pointer: MSB on load, shifts right per compare, flags bit 0
module sar_bit_ptr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] ptr,
  output logic             last
);

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= MSB;
    end else if (shift) begin
      ptr <= ptr >> 1;
    end
  end

  assign last = ptr[0];

endmodule

// File: rtl/sar_compare_ctrl.sv
// rtl/sar_compare_ctrl.sv - MSB-first successive-approximation search over an external comparator
// Optional SAR_EARLY_EXIT_EN: a clean equal compare finishes the search at once.
module sar_compare_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ptr;
  logic             last;
  logic             accept;
  logic             in_try;
  logic             clean;
  logic             keep;
  logic             early;
  logic [WIDTH-1:0] kept;

  assign accept = (state_q == S_IDLE) && start;
  assign in_try = (state_q == S_TRY);

  sar_bit_ptr #(.WIDTH(WIDTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (in_try),
    .ptr   (ptr),
    .last  (last)
  );

  // A malformed compare counts as "target below trial": the bit is dropped.
  always_comb begin
    clean = one_hot3(cmp_eq, cmp_gt, cmp_lt);
    keep  = clean & (cmp_gt | cmp_eq);
    kept  = (trial & ~ptr) | (keep ? ptr : '0);
`ifdef SAR_EARLY_EXIT_EN
    early = clean & cmp_eq;
`else
    early = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_TRY;
      S_TRY:   if (last || early) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      trial   <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        trial <= MSB;
        err   <= 1'b0;
      end else if (in_try) begin
        if (!clean) err <= 1'b1;
        if (early) begin
          result <= trial;
          trial  <= '0;
        end else if (last) begin
          result <= kept;
          trial  <= '0;
        end else begin
          trial <= kept | (ptr >> 1);
        end
      end
    end
  end

  assign busy = in_try;
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// tb/tb_sar_compare_ctrl.sv - self-checking bench for sar_compare_ctrl (WIDTH=4)
module tb_sar_compare_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic         cmp_eq, cmp_gt, cmp_lt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;

  logic [W-1:0] target;
  logic [W-1:0] fmask;
  int           cur_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_tr [4];

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] fm;
    int           ncmp;
    logic [15:0]  tr;
    logic [W-1:0] res;
    logic         e;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sar_compare_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  // Comparator a = target, b = trial, with per-compare corruption (gt and lt both high).
  always_comb begin
    cmp_eq = (target == trial);
    cmp_gt = (target > trial);
    cmp_lt = (target < trial);
    if (busy && cur_idx < W && fmask[cur_idx[1:0]]) begin
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
      cmp_lt = 1'b1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Binary search written directly over bit positions with integer arithmetic.
  task automatic model(input logic [W-1:0] tgt, input logic [W-1:0] fm,
                       output int ncmp, output logic [W-1:0] res, output logic e);
    int val;
    int t;
    int q, g, l;
    val  = 0;
    e    = 1'b0;
    ncmp = 0;
    res  = '0;
    for (int i = 0; i < 4; i++) exp_tr[i] = '0;
    for (int i = W - 1; i >= 0; i--) begin
      t = val + (1 << i);
      exp_tr[ncmp] = t[W-1:0];
      q = (int'(tgt) == t) ? 1 : 0;
      g = (int'(tgt) > t) ? 1 : 0;
      l = (int'(tgt) < t) ? 1 : 0;
      if (fm[ncmp]) begin
        q = 0; g = 1; l = 1;
      end
      ncmp++;
      if (q + g + l != 1) begin
        e = 1'b1;
        continue;
      end
`ifdef SAR_EARLY_EXIT_EN
      if (q == 1) begin
        res = t[W-1:0];
        return;
      end
`endif
      if (q == 1 || g == 1) val = val + (1 << i);
    end
    res = val[W-1:0];
  endtask

  task automatic run_check(input string nm, input logic [W-1:0] tgt, input logic [W-1:0] fm,
                           input int exp_ncmp, input logic [15:0] exp_trs,
                           input logic [W-1:0] exp_res, input logic exp_e, input bit poke);
    int          n, cyc;
    bit          got_done;
    logic [15:0] trs;
    target  = tgt;
    fmask   = fm;
    cur_idx = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; cyc = 0; got_done = 0; trs = '0;
    while (!got_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) begin
        cur_idx = n;
        if (n < 4) trs[15-4*n -: 4] = trial;
        n++;
        if (poke && n == 2) start = 1'b1;
      end
      if (done) got_done = 1;
    end
    start = 1'b0;
    check({nm, " done_seen"}, int'(got_done), 1);
    check({nm, " done_cycle"}, cyc, exp_ncmp + 1);
    check({nm, " compares"}, n, exp_ncmp);
    check({nm, " trials"}, int'(trs), int'(exp_trs));
    check({nm, " result"}, int'(result), int'(exp_res));
    check({nm, " err"}, int'(err), int'(exp_e));
    check({nm, " busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    check({nm, " done_one_cycle"}, int'(done), 0);
    check({nm, " result_held"}, int'(result), int'(exp_res));
    check({nm, " err_held"}, int'(err), int'(exp_e));
  endtask

  initial begin
    int           m_n;
    logic [W-1:0] m_res;
    logic         m_e;
    logic [15:0]  m_tr;
    logic [W-1:0] rt, rf;
    bit           saw_done;

    vecs[0] = '{tgt: 4'd11, fm: 4'b0000, ncmp: 4, tr: 16'h8CAB, res: 4'd11, e: 1'b0};
`ifdef SAR_EARLY_EXIT_EN
    vecs[1] = '{tgt: 4'd12, fm: 4'b0000, ncmp: 2, tr: 16'h8C00, res: 4'd12, e: 1'b0};
`else
    vecs[1] = '{tgt: 4'd12, fm: 4'b0000, ncmp: 4, tr: 16'h8CED, res: 4'd12, e: 1'b0};
`endif
    vecs[2] = '{tgt: 4'd0,  fm: 4'b0000, ncmp: 4, tr: 16'h8421, res: 4'd0,  e: 1'b0};
    vecs[3] = '{tgt: 4'd15, fm: 4'b0000, ncmp: 4, tr: 16'h8CEF, res: 4'd15, e: 1'b0};
    vecs[4] = '{tgt: 4'd11, fm: 4'b0110, ncmp: 4, tr: 16'h8CA9, res: 4'd9,  e: 1'b1};
    vecs[5] = '{tgt: 4'd11, fm: 4'b0000, ncmp: 4, tr: 16'h8CAB, res: 4'd11, e: 1'b0};

    rst = 1'b1; start = 1'b0; target = '0; fmask = '0; cur_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset trial", int'(trial), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset err", int'(err), 0);

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].fm, vecs[i].ncmp,
                vecs[i].tr, vecs[i].res, vecs[i].e, 1'b0);

    // start pulsed during a run must not disturb it or queue another one
    run_check("start_while_busy", vecs[0].tgt, 4'b0000, vecs[0].ncmp, vecs[0].tr,
              vecs[0].res, 1'b0, 1'b1);
    check("no_relaunch busy", int'(busy), 0);

    // reset on the second compare cycle aborts the run
    target = 4'd11; fmask = '0; cur_idx = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort trial", int'(trial), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort stays idle", int'(saw_done), 0);

    for (int i = 0; i < 40; i++) begin
      rt = W'($urandom_range(0, 15));
      rf = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : '0;
      model(rt, rf, m_n, m_res, m_e);
      m_tr = {exp_tr[0], exp_tr[1], exp_tr[2], exp_tr[3]};
      run_check($sformatf("rand%0d t=%0d f=%0h", i, rt, rf), rt, rf, m_n, m_tr, m_res, m_e, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
